// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: command codes, datapath
// op codes, FSM state encoding and the default operand width.
package alu_pkg;

  localparam int WIDTH_DEF = 4;

  // Command codes on cmd_code; 6 and 7 are always illegal.
  localparam logic [2:0] CMD_PASS = 3'd0;
  localparam logic [2:0] CMD_ADD  = 3'd1;
  localparam logic [2:0] CMD_SUB  = 3'd2;
  localparam logic [2:0] CMD_NEG  = 3'd3;
  localparam logic [2:0] CMD_INC  = 3'd4;
  localparam logic [2:0] CMD_MUL  = 3'd5;

  // Op codes understood by the preprocess block ahead of the adder.
  localparam logic [2:0] OP_PASS_A = 3'b000;
  localparam logic [2:0] OP_NEG_A  = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_INC_A  = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SUB2,
    ST_MUL_IT,
    ST_RESP
  } state_e;

  // MUL is only legal when the multiplier sequence is built in.
  function automatic logic cmd_legal(input logic [2:0] code, input logic mul_en);
    case (code)
      CMD_PASS, CMD_ADD, CMD_SUB, CMD_NEG, CMD_INC: cmd_legal = 1'b1;
      CMD_MUL:                                      cmd_legal = mul_en;
      default:                                      cmd_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_rsp_reg.sv
// Response holding register: captures one result on load_i, holds it stable
// while the consumer stalls, and derives the zero flag from the held data.
module alu_rsp_reg
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             cout_i,
  input  logic             err_i,
  input  logic             rsp_ready_i,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_cout_o,
  output logic             rsp_zero_o,
  output logic             rsp_err_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  // Next-state: load a fresh result, drop valid on handshake, else hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cout_d  = cout_q;
    err_d   = err_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      cout_d  = cout_i;
      err_d   = err_i;
    end else if (valid_q && rsp_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid_o = valid_q;
  assign rsp_data_o  = data_q;
  assign rsp_cout_o  = cout_q;
  assign rsp_err_o   = err_q;
  // Gated by valid so the flag reads 0 out of reset rather than "data is 0".
  assign rsp_zero_o  = valid_q && (data_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Command sequencer for the preprocess + adder datapath. Single-pass commands
// use one datapath cycle; SUB uses negate-then-add; MUL is shift-and-add over
// WIDTH iterations with sticky overflow.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_code,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [2:0]       dp_op,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  input  logic [WIDTH-1:0] dp_sum,
  input  logic             dp_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_err
);

  localparam int IW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [2:0]       code_q, code_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [IW-1:0]    i_q, i_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;
  logic             rsp_load;

  logic [WIDTH-1:0] partial;
  logic             shift_lost;
  logic             mul_ovf;

  // Partial product for iteration i and the overflow bits shifted past the top.
  // For i=0 the shift by WIDTH yields zero, so no special case is needed.
  always_comb begin
    partial    = b_q[i_q] ? (a_q << i_q) : '0;
    shift_lost = b_q[i_q] && (|(a_q >> (WIDTH - int'(i_q))));
    mul_ovf    = ovf_q | dp_cout | shift_lost;
  end

  // FSM next-state, datapath drive and working-register updates.
  always_comb begin
    // NOTE: every output and _d gets a default first so no path can leave a
    // value unassigned and infer a latch; blocking '=' is correct in here.
    state_d   = state_q;
    code_d    = code_q;
    a_d       = a_q;
    b_d       = b_q;
    tmp_d     = tmp_q;
    acc_d     = acc_q;
    res_d     = res_q;
    i_d       = i_q;
    ovf_d     = ovf_q;
    cout_d    = cout_q;
    err_d     = err_q;
    dp_op     = OP_PASS_A;
    dp_a      = '0;
    dp_b      = '0;
    rsp_load  = 1'b0;
    cmd_ready = (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          code_d  = cmd_code;
          a_d     = cmd_a;
          b_d     = cmd_b;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_RESP;
        err_d   = 1'b0;
        if (!cmd_legal(code_q, MUL_EN)) begin
          res_d  = '0;
          cout_d = 1'b0;
          err_d  = 1'b1;
        end else begin
          case (code_q)
            CMD_PASS: begin
              dp_op  = OP_PASS_A;
              dp_a   = a_q;
              res_d  = dp_sum;
              cout_d = dp_cout;
            end
            CMD_ADD: begin
              dp_op  = OP_ADD;
              dp_a   = a_q;
              dp_b   = b_q;
              res_d  = dp_sum;
              cout_d = dp_cout;
            end
            CMD_NEG: begin
              dp_op  = OP_NEG_A;
              dp_a   = a_q;
              res_d  = dp_sum;
              cout_d = dp_cout;
            end
            CMD_INC: begin
              dp_op  = OP_INC_A;
              dp_a   = a_q;
              res_d  = dp_sum;
              cout_d = dp_cout;
            end
            CMD_SUB: begin
              // First pass forms -B; the second pass adds it to A.
              dp_op   = OP_NEG_A;
              dp_a    = b_q;
              tmp_d   = dp_sum;
              state_d = ST_SUB2;
            end
            CMD_MUL: begin
              dp_op   = OP_ADD;
              acc_d   = '0;
              i_d     = '0;
              ovf_d   = 1'b0;
              state_d = ST_MUL_IT;
            end
            default: ;
          endcase
        end
      end

      ST_SUB2: begin
        dp_op   = OP_ADD;
        dp_a    = a_q;
        dp_b    = tmp_q;
        res_d   = dp_sum;
        cout_d  = dp_cout;
        state_d = ST_RESP;
      end

      ST_MUL_IT: begin
        dp_op = OP_ADD;
        dp_a  = acc_q;
        dp_b  = partial;
        acc_d = dp_sum;
        ovf_d = mul_ovf;
        i_d   = i_q + 1'b1;
        if (i_q == IW'(WIDTH - 1)) begin
          res_d   = dp_sum;
          cout_d  = mul_ovf;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        // First RESP cycle loads the holding register; leave once it is taken.
        rsp_load = !rsp_valid;
        if (rsp_valid && rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and working registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tmp_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      i_q     <= '0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking '<=' so every register samples pre-edge values.
      state_q <= state_d;
      code_q  <= code_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tmp_q   <= tmp_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      i_q     <= i_d;
      ovf_q   <= ovf_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  alu_rsp_reg #(.WIDTH(WIDTH)) u_rsp_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (rsp_load),
    .data_i      (res_q),
    .cout_i      (cout_q),
    .err_i       (err_q),
    .rsp_ready_i (rsp_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_cout_o  (rsp_cout),
    .rsp_zero_o  (rsp_zero),
    .rsp_err_o   (rsp_err)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural datapath answers dp_* and an
// arithmetic reference model predicts every response and its latency.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_code;
  logic [3:0] cmd_a, cmd_b;
  logic [2:0] dp_op;
  logic [3:0] dp_a, dp_b, dp_sum;
  logic       dp_cout;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_cout, rsp_zero, rsp_err;

  int checks   = 0;
  int failures = 0;
  logic [2:0] ops_seen[$];

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(4), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_code  (cmd_code),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .dp_op     (dp_op),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_sum    (dp_sum),
    .dp_cout   (dp_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_cout  (rsp_cout),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err)
  );

  // Preprocess + 4-bit adder seen by the sequencer.
  function automatic logic [4:0] dp_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'b000:  return {1'b0, a};
      3'b001:  return {1'b0, ~a} + 5'd1;
      3'b010:  return {1'b0, a} + {1'b0, b};
      3'b011:  return {1'b0, a} + 5'd1;
      default: return 5'd0;
    endcase
  endfunction

  assign {dp_cout, dp_sum} = dp_model(dp_op, dp_a, dp_b);

  // Expected response and accept-to-valid latency from the command semantics.
  function automatic void ref_model(input int code, input int a, input int b,
                                    output int d, output int c, output int e, output int l);
    int s;
    d = 0; c = 0; e = 0; l = 2;
    case (code)
      0: d = a;
      1: begin s = a + b; d = s % 16; c = int'(s > 15); end
      2: begin s = a + ((16 - b) % 16); d = s % 16; c = int'(s > 15); l = 3; end
      3: begin d = (16 - a) % 16; c = int'(a == 0); end
      4: begin s = a + 1; d = s % 16; c = int'(s > 15); end
      5: begin s = a * b; d = s % 16; c = int'(s > 15); l = 6; end
      default: e = 1;
    endcase
  endfunction

  task automatic test_reset_values(input string tag);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_cout, rsp_zero, rsp_err, dp_op, rsp_data, dp_a, dp_b} !== {1'b1, 7'b0, 12'b0}) begin
      failures++;
      $display("FAIL %s: ready=%b valid=%b cout=%b zero=%b err=%b op=%b data=%0d a=%0d b=%0d, required ready=1 and all others 0",
               tag, cmd_ready, rsp_valid, rsp_cout, rsp_zero, rsp_err, dp_op, rsp_data, dp_a, dp_b);
    end
  endtask

  // Issue one command at a negedge, keep junk on cmd_* while busy, stall the
  // response for 'hold' cycles, then complete it. Records dp_op per cycle.
  task automatic do_cmd(input int code, input int a, input int b, input int hold);
    int ed, ec, ee, el, lat;
    ref_model(code, a, b, ed, ec, ee, el);
    ops_seen.delete();
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL idle_ready: got %b required 1", cmd_ready); end
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1; cmd_code = 3'(code); cmd_a = 4'(a); cmd_b = 4'(b);
    @(posedge clk); @(negedge clk);
    cmd_code = 3'($urandom_range(0, 7)); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      ops_seen.push_back(dp_op);
      checks++;
      if (cmd_ready !== 1'b0) begin failures++; $display("FAIL busy_ready: got %b required 0", cmd_ready); end
      @(posedge clk); lat++; @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++;
    if (lat !== el) begin failures++; $display("FAIL latency code=%0d: got %0d required %0d", code, lat, el); end
    checks++;
    if (rsp_data !== 4'(ed)) begin failures++; $display("FAIL data code=%0d a=%0d b=%0d: got %0d required %0d", code, a, b, rsp_data, ed); end
    checks++;
    if (rsp_cout !== 1'(ec)) begin failures++; $display("FAIL cout code=%0d a=%0d b=%0d: got %b required %0d", code, a, b, rsp_cout, ec); end
    checks++;
    if (rsp_zero !== (ed == 0)) begin failures++; $display("FAIL zero code=%0d: got %b required %b", code, rsp_zero, (ed == 0)); end
    checks++;
    if (rsp_err !== 1'(ee)) begin failures++; $display("FAIL err code=%0d: got %b required %0d", code, rsp_err, ee); end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 4'(ed) || rsp_cout !== 1'(ec) || cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold cycle %0d: valid=%b data=%0d cout=%b ready=%b required 1/%0d/%0d/0",
                 k, rsp_valid, rsp_data, rsp_cout, cmd_ready, ed, ec);
      end
    end
    rsp_ready = 1'b1;
    checks++;
    if (cmd_ready !== 1'b0) begin failures++; $display("FAIL ready_before_handshake: got %b required 0", cmd_ready); end
    @(posedge clk); @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL after_handshake: valid=%b ready=%b required 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_code = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    #1;
    test_reset_values("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset_values("after_reset_release");
  endtask

  task automatic test_add();
    do_cmd(1, 7, 5, 0);
    checks++;
    if (ops_seen.size() < 1 || ops_seen[0] !== 3'b010) begin
      failures++; $display("FAIL add_exec_op: got %b required 010", ops_seen.size() > 0 ? ops_seen[0] : 3'bx);
    end
    do_cmd(0, 9, 3, 0);
    do_cmd(1, 15, 1, 0);
  endtask

  task automatic test_sub();
    do_cmd(2, 5, 3, 0);
    checks++;
    if (ops_seen.size() < 2 || ops_seen[0] !== 3'b001 || ops_seen[1] !== 3'b010) begin
      failures++; $display("FAIL sub_op_sequence: got %0d entries, required 001 then 010", ops_seen.size());
    end
    do_cmd(2, 3, 5, 0);
    do_cmd(2, 6, 0, 0);
  endtask

  task automatic test_mul();
    int n_add;
    do_cmd(5, 3, 5, 0);
    do_cmd(5, 6, 5, 0);
    n_add = 0;
    foreach (ops_seen[k]) if (ops_seen[k] == 3'b010) n_add++;
    checks++;
    if (n_add != 5) begin failures++; $display("FAIL mul_add_passes: got %0d required 5", n_add); end
    do_cmd(5, 15, 15, 0);
    do_cmd(5, 0, 9, 0);
  endtask

  task automatic test_neg_illegal();
    int bad;
    do_cmd(3, 0, 0, 0);
    do_cmd(3, 1, 0, 0);
    do_cmd(6, 4, 4, 0);
    bad = 0;
    foreach (ops_seen[k]) if (ops_seen[k] != 3'b000) bad++;
    checks++;
    if (bad != 0 || ops_seen.size() == 0) begin
      failures++; $display("FAIL illegal_dp_op: got %0d non-000 ops in %0d cycles, required 0", bad, ops_seen.size());
    end
    do_cmd(7, 2, 2, 0);
  endtask

  task automatic test_backpressure();
    do_cmd(4, 15, 0, 5);
    do_cmd(2, 9, 4, 2);
  endtask

  task automatic test_reset_mid_mul();
    cmd_valid = 1'b1; cmd_code = 3'd5; cmd_a = 4'd7; cmd_b = 4'd15;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    checks++;
    if (dp_op !== 3'b010) begin failures++; $display("FAIL mul_iter_op: got %b required 010", dp_op); end
    #2 rst_n = 1'b0;
    #1 test_reset_values("reset_mid_mul");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        failures++; $display("FAIL aborted_no_rsp cycle %0d: valid=%b ready=%b required 0/1", k, rsp_valid, cmd_ready);
      end
    end
    do_cmd(1, 1, 1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      do_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)));
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_neg_illegal();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
